// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage with a valid/ready handshake
// on both sides. Holds its result until downstream accepts it, and sustains
// one operation per cycle when downstream is always ready.
//
// Optional feature macro: ALU_EXEC_MUL_EN
//   When defined, code 011 is an unsigned multiply (low WIDTH bits) computed
//   by an iterative shift-add, one multiplier bit per cycle. When undefined,
//   code 011 is treated like any other undefined code (result 0, Zero=1).

module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALU_control,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             Zero,
  output logic             Overflow
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

`ifdef ALU_EXEC_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`endif

  state_t state;

  logic             accept;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_zero;

`ifdef ALU_EXEC_MUL_EN
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_acc_next;
  logic [CNT_W-1:0] mul_cnt;
  logic             start_mul;
`endif

  // A new operation may enter when idle, or when the held result leaves this same cycle
  always_comb begin
    in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    accept   = in_valid && in_ready;
  end

  // Single-cycle datapath; slt uses the operand signs when they differ so A-B overflow cannot flip it
  always_comb begin
    sum      = SrcA + SrcB;
    diff     = SrcA - SrcB;
    slt_bit  = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) ? SrcA[WIDTH-1] : diff[WIDTH-1];
    alu_res  = '0;
    alu_ovf  = 1'b0;
    case (ALU_control)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_AND:  alu_res = SrcA & SrcB;
      OP_OR:   alu_res = SrcA | SrcB;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
  end

`ifdef ALU_EXEC_MUL_EN
  // Partial-product accumulation for the current multiplier bit
  always_comb begin
    start_mul    = (ALU_control == OP_MUL);
    mul_acc_next = mul_b[0] ? (mul_acc + mul_a) : mul_acc;
  end

  // Shift-add multiplier registers: load on accept, shift one bit per MUL cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_cnt <= '0;
    end else if (accept && start_mul) begin
      mul_a   <= SrcA;
      mul_b   <= SrcB;
      mul_acc <= '0;
      mul_cnt <= CNT_W'(WIDTH);
    end else if (state == MUL) begin
      mul_a   <= mul_a << 1;
      mul_b   <= mul_b >> 1;
      mul_acc <= mul_acc_next;
      mul_cnt <= mul_cnt - CNT_W'(1);
    end
  end
`endif

  // Control FSM with registered result, flags and out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      ALU_result <= '0;
      Zero       <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      case (state)
`ifdef ALU_EXEC_MUL_EN
        MUL: begin
          if (mul_cnt == CNT_W'(1)) begin
            ALU_result <= mul_acc_next;
            Zero       <= (mul_acc_next == '0);
            Overflow   <= 1'b0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
`endif
        default: begin
`ifdef ALU_EXEC_MUL_EN
          if (accept && start_mul) begin
            out_valid <= 1'b0;
            state     <= MUL;
          end else
`endif
          if (accept) begin
            ALU_result <= alu_res;
            Zero       <= alu_zero;
            Overflow   <= alu_ovf;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if ((state == DONE) && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed self-checking bench for alu_exec_stage.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, so each check sees the state left by the previous edge.

module tb_alu_exec_stage;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALU_control;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_result;
  logic             Zero;
  logic             Overflow;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
  } vec_t;

  vec_t vecs [10] = '{
    '{3'b110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1},
    '{3'b110, 32'h00000009, 32'h00000009, 32'h00000000, 1'b1, 1'b0},
    '{3'b111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
    '{3'b111, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0},
    '{3'b000, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0},
    '{3'b001, 32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 1'b0, 1'b0},
    '{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1},
    '{3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0},
    '{3'b111, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0},
    '{3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1}
  };

  alu_exec_stage #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALU_control (ALU_control),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALU_result  (ALU_result),
    .Zero        (Zero),
    .Overflow    (Overflow)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    ALU_control = 3'b100;
    SrcA        = '0;
    SrcB        = '0;
    step();
    step();
    tests_run++;
    if ({out_valid, ALU_result, Zero, Overflow} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got valid=%b res=%h z=%b o=%b, want 0/0/0/0",
               out_valid, ALU_result, Zero, Overflow);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    ALU_control = 3'b010;
    SrcA        = 32'd5;
    SrcB        = 32'd7;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    step();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, ALU_result, Zero, Overflow} !== {1'b1, 32'd12, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL add_5_7: got valid=%b res=%h z=%b o=%b, want 1/0000000c/0/0",
               out_valid, ALU_result, Zero, Overflow);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL add_valid_drop: got %b, want 0", out_valid);
    end
  endtask

  task automatic test_arith();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ALU_control = vecs[i].ctrl;
      SrcA        = vecs[i].a;
      SrcB        = vecs[i].b;
      in_valid    = 1'b1;
      step();
      in_valid = 1'b0;
      tests_run++;
      if ({out_valid, ALU_result, Zero, Overflow} !== {1'b1, vecs[i].res, vecs[i].z, vecs[i].o}) begin
        tests_failed++;
        $display("[TB] FAIL arith_vec%0d ctrl=%b: got valid=%b res=%h z=%b o=%b, want 1/%h/%b/%b",
                 i, vecs[i].ctrl, out_valid, ALU_result, Zero, Overflow,
                 vecs[i].res, vecs[i].z, vecs[i].o);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    out_ready   = 1'b0;
    ALU_control = 3'b010;
    SrcA        = 32'd1;
    SrcB        = 32'd2;
    in_valid    = 1'b1;
    step();
    // inputs offered during the stall must be ignored
    ALU_control = 3'b110;
    SrcA        = 32'd100;
    SrcB        = 32'd1;
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if ({out_valid, ALU_result, in_ready} !== {1'b1, 32'd3, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold_c%0d: got valid=%b res=%h in_ready=%b, want 1/00000003/0",
                 c, out_valid, ALU_result, in_ready);
      end
      step();
    end
    out_ready   = 1'b1;
    ALU_control = 3'b110;
    SrcA        = 32'd10;
    SrcB        = 32'd4;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL release_in_ready: got %b, want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, ALU_result} !== {1'b1, 32'd6}) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back: got valid=%b res=%h, want 1/00000006", out_valid, ALU_result);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back_drain: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_nop_undef();
    logic [2:0] codes [3];
    codes[0] = 3'b100;
    codes[1] = 3'b101;
    codes[2] = 3'b100;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // a nonzero result first, so a stale Zero would show up
      ALU_control = 3'b001;
      SrcA        = 32'h00000055;
      SrcB        = 32'h000000AA;
      in_valid    = 1'b1;
      step();
      ALU_control = codes[i];
      SrcA        = 32'h12345678;
      SrcB        = 32'h9ABCDEF0;
      step();
      in_valid = 1'b0;
      tests_run++;
      if ({out_valid, ALU_result, Zero, Overflow} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL nop_code_%b: got valid=%b res=%h z=%b o=%b, want 1/00000000/1/0",
                 codes[i], out_valid, ALU_result, Zero, Overflow);
      end
      step();
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL nop_beat_%b: got valid=%b, want 0", codes[i], out_valid);
      end
    end
  endtask

`ifdef ALU_EXEC_MUL_EN
  task automatic test_mul();
    int bad_cycle;
    int seen_valid;
    out_ready   = 1'b1;
    ALU_control = 3'b011;
    SrcA        = 32'h00010003;
    SrcB        = 32'h00000005;
    in_valid    = 1'b1;
    step();
    in_valid  = 1'b0;
    bad_cycle = -1;
    for (int c = 1; c < 32; c++) begin
      if ((in_ready !== 1'b0 || out_valid !== 1'b0) && bad_cycle < 0) bad_cycle = c;
      step();
    end
    if ((in_ready !== 1'b0 || out_valid !== 1'b0) && bad_cycle < 0) bad_cycle = 32;
    tests_run++;
    if (bad_cycle >= 0) begin
      tests_failed++;
      $display("[TB] FAIL mul_busy: in_ready/out_valid high at cycle %0d, want 0 for 32 cycles", bad_cycle);
    end
    step();
    tests_run++;
    if ({out_valid, ALU_result, Zero, Overflow} !== {1'b1, 32'h0005000F, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL mul_result: got valid=%b res=%h z=%b o=%b, want 1/0005000f/0/0",
               out_valid, ALU_result, Zero, Overflow);
    end
    step();
    // abort a multiply partway through with reset
    ALU_control = 3'b011;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) step();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL mul_abort: got valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
    step();
    rst        = 1'b0;
    seen_valid = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid === 1'b1) seen_valid++;
      step();
    end
    tests_run++;
    if (seen_valid != 0) begin
      tests_failed++;
      $display("[TB] FAIL mul_abort_silent: got %0d valid cycles, want 0", seen_valid);
    end
  endtask
`else
  task automatic test_mul();
    out_ready   = 1'b1;
    ALU_control = 3'b011;
    SrcA        = 32'h00010003;
    SrcB        = 32'h00000005;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, ALU_result, Zero, Overflow} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL mul_disabled: got valid=%b res=%h z=%b o=%b, want 1/00000000/1/0",
               out_valid, ALU_result, Zero, Overflow);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mul_disabled_beat: got valid=%b, want 0", out_valid);
    end
  endtask
`endif

  // Test sequence
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_add();
    test_arith();
    test_backpressure();
    test_nop_undef();
    test_mul();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
